axis_lattice_loader: RTL and testbench

AXI4-Stream slave that loads one full lattice frame into the nine per-direction distribution BRAMs. Each 144-bit beat carries the nine 16-bit direction values of one cell; beat k is written to BRAM address k. After all DEPTH cells are committed, the block pulses `frame_ready` to start the downstream BRAM-to-stream controller. It is the stage directly upstream of that controller.

---
 rtl/axis_lattice_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_axis_lattice_loader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_lattice_loader.sv
// ---------------------------------------------------------------------------
// axis_lattice_loader
//
// AXI4-Stream slave that loads one complete lattice frame into the nine
// per-direction distribution BRAMs. Every beat carries the nine direction
// values of one cell, and beat k is written to BRAM address k. When all DEPTH
// cells have been committed, the block pulses frame_ready for one cycle. That
// pulse starts the downstream BRAM-to-stream controller.
//
// Optional feature macro: LOADER_TLAST_CHECK_EN
//   defined   : tlast is checked against the beat count. On an early or a
//               missing tlast, frame_error is set and no frame_ready is
//               produced. A missing tlast parks the block in DRAIN, where
//               beats are discarded until a tlast beat arrives.
//   undefined : tlast is ignored, a frame is exactly DEPTH beats, and
//               frame_error is tied low.
//
// Ports
//   s00_axis_aclk    : sole clock
//   s00_axis_areset  : synchronous active-high reset
//   arm              : level, sampled in IDLE to start accepting a frame
//   s00_axis_tvalid  : beat valid
//   s00_axis_tready  : beat accepted when tvalid & tready (decoded from state)
//   s00_axis_tdata   : lanes MSB->LSB: null, n, ne, e, se, s, sw, w, nw
//   s00_axis_tstrb   : byte strobes; a lane is written only if all its bytes
//                      are strobed
//   s00_axis_tlast   : final beat of a frame
//   wr_addr          : BRAM write address shared by all nine BRAMs
//   wr_we            : per-lane write enable, bit 8 = null ... bit 0 = nw
//   wr_null..wr_nw   : lane write data
//   frame_ready      : one-cycle pulse once the full frame is committed
//   busy             : high in every state except IDLE
//   frame_error      : sticky tlast-mismatch flag, cleared by the next arm
// ---------------------------------------------------------------------------
module axis_lattice_loader #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                         s00_axis_aclk,
  input  logic                         s00_axis_areset,
  input  logic                         arm,
  input  logic                         s00_axis_tvalid,
  output logic                         s00_axis_tready,
  input  logic [9*DATA_WIDTH-1:0]      s00_axis_tdata,
  input  logic [9*DATA_WIDTH/8-1:0]    s00_axis_tstrb,
  input  logic                         s00_axis_tlast,
  output logic [ADDRESS_WIDTH-1:0]     wr_addr,
  output logic [8:0]                   wr_we,
  output logic [DATA_WIDTH-1:0]        wr_null,
  output logic [DATA_WIDTH-1:0]        wr_n,
  output logic [DATA_WIDTH-1:0]        wr_ne,
  output logic [DATA_WIDTH-1:0]        wr_e,
  output logic [DATA_WIDTH-1:0]        wr_se,
  output logic [DATA_WIDTH-1:0]        wr_s,
  output logic [DATA_WIDTH-1:0]        wr_sw,
  output logic [DATA_WIDTH-1:0]        wr_w,
  output logic [DATA_WIDTH-1:0]        wr_nw,
  output logic                         frame_ready,
  output logic                         busy,
  output logic                         frame_error
);

  localparam int LANES       = 9;
  localparam int LANE_BYTES  = DATA_WIDTH / 8;
  localparam int FRAME_WIDTH = LANES * DATA_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [LANES-1:0]         we_q, we_d;
  logic [FRAME_WIDTH-1:0]   data_q, data_d;
  logic                     frame_ready_q, frame_ready_d;
  logic [LANES-1:0]         lane_we;
  logic                     beat_fire;

`ifdef LOADER_TLAST_CHECK_EN
  logic                     err_q, err_d;
`else
  logic                     unused_tlast;
  assign unused_tlast = s00_axis_tlast;
`endif

  // tready is a pure decode of the state register, so it never depends
  // combinationally on tvalid. DRAIN keeps accepting beats so that a stream
  // with a missing tlast can be flushed.
  assign s00_axis_tready = (state_q == RECV) || (state_q == DRAIN);
  assign beat_fire       = s00_axis_tvalid && s00_axis_tready;

  // A lane is written only when every byte of it is strobed. A partially
  // strobed lane is dropped, because a half-written direction value would
  // corrupt the distribution.
  always_comb begin
    lane_we = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_we[i] = &s00_axis_tstrb[i*LANE_BYTES +: LANE_BYTES];
    end
  end

  // Next-state logic for the loader FSM and its registered write port.
  // wr_we defaults to zero, so a write is emitted only in the cycle after an
  // accepted beat. Address and lane data hold their last value between
  // writes, which is harmless because nothing is written then. The counter
  // stops at DEPTH-1 and is cleared only by the next arm, so it never wraps
  // inside a frame.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    we_d          = '0;
    data_d        = data_q;
    frame_ready_d = 1'b0;
`ifdef LOADER_TLAST_CHECK_EN
    err_d         = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = RECV;
          cnt_d   = '0;
`ifdef LOADER_TLAST_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      RECV: begin
        if (beat_fire) begin
          data_d = s00_axis_tdata;
          addr_d = cnt_q;
          we_d   = lane_we;
`ifdef LOADER_TLAST_CHECK_EN
          if (cnt_q == LAST_ADDR) begin
            if (s00_axis_tlast) begin
              state_d = DONE;
            end else begin
              state_d = DRAIN;
              err_d   = 1'b1;
            end
          end else if (s00_axis_tlast) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDRESS_WIDTH'(1);
          end
`else
          if (cnt_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + ADDRESS_WIDTH'(1);
          end
`endif
        end
      end
      DONE: begin
        // The last write went out in the cycle before this one, so the BRAMs
        // already hold the whole frame when the pulse reaches the next stage.
        frame_ready_d = 1'b1;
        state_d       = IDLE;
      end
      DRAIN: begin
`ifdef LOADER_TLAST_CHECK_EN
        if (beat_fire && s00_axis_tlast) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any partial frame and returns
  // every output to zero at the next edge.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      we_q          <= '0;
      data_q        <= '0;
      frame_ready_q <= 1'b0;
`ifdef LOADER_TLAST_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      data_q        <= data_d;
      frame_ready_q <= frame_ready_d;
`ifdef LOADER_TLAST_CHECK_EN
      err_q         <= err_d;
`endif
    end
  end

  assign wr_addr     = addr_q;
  assign wr_we       = we_q;
  assign wr_null     = data_q[8*DATA_WIDTH +: DATA_WIDTH];
  assign wr_n        = data_q[7*DATA_WIDTH +: DATA_WIDTH];
  assign wr_ne       = data_q[6*DATA_WIDTH +: DATA_WIDTH];
  assign wr_e        = data_q[5*DATA_WIDTH +: DATA_WIDTH];
  assign wr_se       = data_q[4*DATA_WIDTH +: DATA_WIDTH];
  assign wr_s        = data_q[3*DATA_WIDTH +: DATA_WIDTH];
  assign wr_sw       = data_q[2*DATA_WIDTH +: DATA_WIDTH];
  assign wr_w        = data_q[1*DATA_WIDTH +: DATA_WIDTH];
  assign wr_nw       = data_q[0 +: DATA_WIDTH];
  assign frame_ready = frame_ready_q;
  assign busy        = (state_q != IDLE);
`ifdef LOADER_TLAST_CHECK_EN
  assign frame_error = err_q;
`else
  assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_axis_lattice_loader.sv
// ---------------------------------------------------------------------------
// tb_axis_lattice_loader
//
// Directed bench for axis_lattice_loader with DEPTH = 4. Beats are driven on
// the falling edge and accepted on the rising edge. Every beat that should
// reach the BRAMs is pushed into a queue of expected writes. A monitor on the
// falling edge pops one entry for each cycle in which wr_we is non-zero and
// compares address, enables and lane data against it.
// ---------------------------------------------------------------------------
module tb_axis_lattice_loader;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 12;
  localparam logic [17:0] ALL_STRB = 18'h3FFFF;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [8:0]    we;
    logic [143:0]  data;
  } wr_t;

  logic          aclk;
  logic          areset;
  logic          arm;
  logic          tValid;
  logic          tReady;
  logic [143:0]  tData;
  logic [17:0]   tStrb;
  logic          tLast;
  logic [AW-1:0] wrAddr;
  logic [8:0]    wrWe;
  logic [DW-1:0] wrNull, wrN, wrNe, wrE, wrSe, wrS, wrSw, wrW, wrNw;
  logic          frameReady;
  logic          busy;
  logic          frameError;

  wr_t expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  frameReadyCount = 0;
  int  readyBefore;

  axis_lattice_loader #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .s00_axis_aclk  (aclk),
    .s00_axis_areset(areset),
    .arm            (arm),
    .s00_axis_tvalid(tValid),
    .s00_axis_tready(tReady),
    .s00_axis_tdata (tData),
    .s00_axis_tstrb (tStrb),
    .s00_axis_tlast (tLast),
    .wr_addr        (wrAddr),
    .wr_we          (wrWe),
    .wr_null        (wrNull),
    .wr_n           (wrN),
    .wr_ne          (wrNe),
    .wr_e           (wrE),
    .wr_se          (wrSe),
    .wr_s           (wrS),
    .wr_sw          (wrSw),
    .wr_w           (wrW),
    .wr_nw          (wrNw),
    .frame_ready    (frameReady),
    .busy           (busy),
    .frame_error    (frameError)
  );

  // Free-running clock, period 10.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Hard stop in case the stimulus ever gets stuck.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and on a difference count the failure and
  // report the tag with both values.
  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Beat k carries the value 16*k + i in lane i, where lane 0 is nw.
  function automatic logic [143:0] makeBeat(input int k);
    logic [143:0] d;
    d = '0;
    for (int i = 0; i < 9; i++) begin
      d[i*16 +: 16] = 16'(16 * k + i);
    end
    return d;
  endfunction

  // Drive one beat and wait, within a bound, until it is accepted. When the
  // beat should reach the BRAMs, the expected write is queued for the
  // monitor.
  task automatic applyStimulus(input int k, input logic [17:0] strb,
                               input logic [8:0] expWe, input logic last,
                               input logic expWrite);
    int  waitN;
    wr_t e;
    waitN = 0;
    @(negedge aclk);
    tValid = 1'b1;
    tData  = makeBeat(k);
    tStrb  = strb;
    tLast  = last;
    while (!tReady && waitN < 20) begin
      @(negedge aclk);
      waitN++;
    end
    checkOutput("tready before beat", 160'(tReady), 160'(1'b1));
    if (tReady) begin
      if (expWrite) begin
        e.addr = AW'(k);
        e.we   = expWe;
        e.data = makeBeat(k);
        expQ.push_back(e);
      end
      @(posedge aclk);
    end else begin
      tValid = 1'b0;
    end
  endtask

  task automatic gapCycles(input int n);
    repeat (n) begin
      @(negedge aclk);
      tValid = 1'b0;
    end
  endtask

  task automatic armFrame();
    @(negedge aclk);
    arm = 1'b1;
    @(negedge aclk);
    arm = 1'b0;
  endtask

  // The last beat was accepted at edge t. Its write shows up in cycle t+1,
  // frame_ready in cycle t+2, and the pulse lasts exactly one cycle.
  task automatic finishFrame();
    @(negedge aclk);
    tValid = 1'b0;
    tLast  = 1'b0;
    checkOutput("frame_ready not before write", 160'(frameReady), 160'(1'b0));
    checkOutput("last write address", 160'(wrAddr), 160'(DEPTH - 1));
    @(negedge aclk);
    checkOutput("frame_ready pulse", 160'(frameReady), 160'(1'b1));
    checkOutput("busy after frame", 160'(busy), 160'(1'b0));
    @(negedge aclk);
    #1;
    checkOutput("frame_ready one cycle", 160'(frameReady), 160'(1'b0));
    checkOutput("write queue drained", 160'(expQ.size()), 160'(0));
  endtask

  // A full four-beat frame with tlast on beat 3. Beat 1 uses strb1 and
  // expects we1. Random idle cycles of up to maxGap are inserted between
  // beats.
  task automatic loadFrame(input logic [17:0] strb1, input logic [8:0] we1,
                           input int maxGap);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(k, (k == 1) ? strb1 : ALL_STRB, (k == 1) ? we1 : 9'h1FF,
                    k == DEPTH - 1, 1'b1);
      if (maxGap > 0 && k < DEPTH - 1) begin
        gapCycles($urandom_range(0, maxGap));
      end
    end
    finishFrame();
  endtask

  // Scoreboard monitor: every cycle with a write must match the oldest
  // queued expectation. A write with nothing queued is reported as well.
  always @(negedge aclk) begin : monitor
    wr_t e;
    if (frameReady === 1'b1) begin
      frameReadyCount++;
    end
    if (wrWe !== 9'h000) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected write", 160'({wrAddr, wrWe}), 160'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr", 160'(wrAddr), 160'(e.addr));
        checkOutput("wr_we", 160'(wrWe), 160'(e.we));
        checkOutput("wr_data",
                    160'({wrNull, wrN, wrNe, wrE, wrSe, wrS, wrSw, wrW, wrNw}),
                    160'(e.data));
      end
    end
  end

  initial begin
    areset = 1'b1;
    arm    = 1'b0;
    tValid = 1'b0;
    tData  = '0;
    tStrb  = '0;
    tLast  = 1'b0;

    // Reset state.
    repeat (2) @(negedge aclk);
    checkOutput("reset tready", 160'(tReady), 160'(1'b0));
    checkOutput("reset busy", 160'(busy), 160'(1'b0));
    checkOutput("reset frame_ready", 160'(frameReady), 160'(1'b0));
    checkOutput("reset frame_error", 160'(frameError), 160'(1'b0));
    checkOutput("reset wr_we", 160'(wrWe), 160'(0));
    checkOutput("reset wr_addr", 160'(wrAddr), 160'(0));
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("idle without arm tready", 160'(tReady), 160'(1'b0));

    // Back-to-back frame.
    $display("[TB] back-to-back frame");
    armFrame();
    checkOutput("busy after arm", 160'(busy), 160'(1'b1));
    checkOutput("tready after arm", 160'(tReady), 160'(1'b1));
    loadFrame(ALL_STRB, 9'h1FF, 0);

    // Same frame with random tvalid gaps.
    $display("[TB] frame with tvalid gaps");
    readyBefore = frameReadyCount;
    armFrame();
    loadFrame(ALL_STRB, 9'h1FF, 3);
    checkOutput("single frame_ready with gaps", 160'(frameReadyCount - readyBefore),
                160'(1));

    // Partial strobe on beat 1: only the nw lane is written.
    $display("[TB] partial strobe");
    armFrame();
    loadFrame(18'h00003, 9'h001, 0);

    // Reset in the middle of a frame.
    $display("[TB] mid-frame reset");
    armFrame();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k, ALL_STRB, 9'h1FF, 1'b0, 1'b1);
    end
    @(negedge aclk);
    tValid = 1'b0;
    areset = 1'b1;
    readyBefore = frameReadyCount;
    @(negedge aclk);
    checkOutput("mid reset wr_we", 160'(wrWe), 160'(0));
    checkOutput("mid reset wr_addr", 160'(wrAddr), 160'(0));
    checkOutput("mid reset data",
                160'({wrNull, wrN, wrNe, wrE, wrSe, wrS, wrSw, wrW, wrNw}), 160'(0));
    checkOutput("mid reset busy", 160'(busy), 160'(1'b0));
    checkOutput("mid reset tready", 160'(tReady), 160'(1'b0));
    areset = 1'b0;
    repeat (4) @(negedge aclk);
    #1;
    checkOutput("no frame_ready after reset", 160'(frameReadyCount - readyBefore),
                160'(0));
    armFrame();
    loadFrame(ALL_STRB, 9'h1FF, 0);

`ifdef LOADER_TLAST_CHECK_EN
    // Early tlast on beat 1: both beats written, error set, frame abandoned.
    $display("[TB] early tlast");
    readyBefore = frameReadyCount;
    armFrame();
    applyStimulus(0, ALL_STRB, 9'h1FF, 1'b0, 1'b1);
    applyStimulus(1, ALL_STRB, 9'h1FF, 1'b1, 1'b1);
    @(negedge aclk);
    tValid = 1'b0;
    tLast  = 1'b0;
    checkOutput("early tlast frame_error", 160'(frameError), 160'(1'b1));
    checkOutput("early tlast tready", 160'(tReady), 160'(1'b0));
    repeat (3) @(negedge aclk);
    #1;
    checkOutput("early tlast no frame_ready", 160'(frameReadyCount - readyBefore),
                160'(0));
    checkOutput("early tlast queue drained", 160'(expQ.size()), 160'(0));
    checkOutput("frame_error sticky", 160'(frameError), 160'(1'b1));
    armFrame();
    checkOutput("arm clears frame_error", 160'(frameError), 160'(1'b0));
    loadFrame(ALL_STRB, 9'h1FF, 0);

    // Missing tlast: addresses 0..3 written, beats 4 and 5 drained.
    $display("[TB] missing tlast");
    readyBefore = frameReadyCount;
    armFrame();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(k, ALL_STRB, 9'h1FF, k == 5, k < DEPTH);
    end
    @(negedge aclk);
    tValid = 1'b0;
    tLast  = 1'b0;
    checkOutput("missing tlast frame_error", 160'(frameError), 160'(1'b1));
    checkOutput("missing tlast busy", 160'(busy), 160'(1'b0));
    repeat (3) @(negedge aclk);
    #1;
    checkOutput("missing tlast no frame_ready", 160'(frameReadyCount - readyBefore),
                160'(0));
    checkOutput("missing tlast queue drained", 160'(expQ.size()), 160'(0));
`else
    // tlast on beat 1 is ignored: the frame still runs to four beats.
    $display("[TB] tlast ignored");
    readyBefore = frameReadyCount;
    armFrame();
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(k, ALL_STRB, 9'h1FF, k == 1, 1'b1);
    end
    finishFrame();
    checkOutput("ignored tlast frame_error", 160'(frameError), 160'(1'b0));
    checkOutput("ignored tlast one frame_ready", 160'(frameReadyCount - readyBefore),
                160'(1));
`endif

    repeat (2) @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
